// File: rtl/hex_display_io.sv
// Bus-mapped six-digit seven-segment display: VALUE/CTRL/STATUS registers, registered HEX outputs.
// Optional blinking is compiled in with HEX_DISPLAY_IO_BLINK_EN.
module hex_display_io #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nce,
    input  logic        we,
    input  logic        re,
    input  logic [1:0]  addr,
    input  logic [31:0] d_in,
    output logic [31:0] d_out,
    output logic        d_oe,
    output logic [7:0]  HEX0,
    output logic [7:0]  HEX1,
    output logic [7:0]  HEX2,
    output logic [7:0]  HEX3,
    output logic [7:0]  HEX4,
    output logic [7:0]  HEX5
);

    logic [23:0] value_reg;
    logic [5:0]  dig_en_reg;
    logic [5:0]  dp_mask_reg;
    logic [31:0] d_out_reg;
    logic        d_oe_reg;
    logic        blink_en;
    logic        phase;
    logic        blank_all;
    logic        wr_value;
    logic        wr_ctrl;
    logic        rd;
    logic [31:0] rd_data;
    logic [7:0]  hex_bus [6];
    logic        unused_bits;

    assign wr_value = !nce && we && (addr == 2'd0);
    assign wr_ctrl  = !nce && we && (addr == 2'd1);
    assign rd       = !nce && re;

    always_ff @(posedge clk) begin
        if (rst) begin
            value_reg   <= '0;
            dig_en_reg  <= '0;
            dp_mask_reg <= '0;
        end else begin
            if (wr_value) begin
                value_reg <= d_in[23:0];
            end
            if (wr_ctrl) begin
                dig_en_reg  <= d_in[5:0];
                dp_mask_reg <= d_in[11:6];
            end
        end
    end

`ifdef HEX_DISPLAY_IO_BLINK_EN
    localparam int CW = $clog2(BLINK_DIV);

    logic [CW-1:0] cnt_reg;
    logic          phase_reg;
    logic          blink_en_reg;

    // A CTRL write restarts the blink period so newly written digits show immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            phase_reg    <= 1'b0;
            blink_en_reg <= 1'b0;
        end else if (wr_ctrl) begin
            cnt_reg      <= '0;
            phase_reg    <= 1'b0;
            blink_en_reg <= d_in[12];
        end else if (cnt_reg == CW'(BLINK_DIV - 1)) begin
            cnt_reg   <= '0;
            phase_reg <= ~phase_reg;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign blink_en    = blink_en_reg;
    assign phase       = phase_reg;
    assign unused_bits = &{1'b0, d_in[31:24]};
`else
    assign blink_en    = 1'b0;
    assign phase       = 1'b0;
    assign unused_bits = &{1'b0, d_in[31:24], d_in[12], (BLINK_DIV < 2)};
`endif

    assign blank_all = blink_en && phase;

    // Read data reflects register contents before any same-edge write.
    always_comb begin
        rd_data = '0;
        case (addr)
            2'd0:    rd_data = {8'd0, value_reg};
            2'd1:    rd_data = {19'd0, blink_en, dp_mask_reg, dig_en_reg};
            2'd2:    rd_data = {31'd0, phase};
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_out_reg <= '0;
            d_oe_reg  <= 1'b0;
        end else if (rd) begin
            d_out_reg <= rd_data;
            d_oe_reg  <= 1'b1;
        end else begin
            d_out_reg <= '0;
            d_oe_reg  <= 1'b0;
        end
    end

    assign d_out = d_out_reg;
    assign d_oe  = d_oe_reg;

    // Active-low segments, bits 6:0 = g..a.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        s = 7'h7F;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_digit
            logic [7:0] seg_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    seg_reg <= 8'hFF;
                end else if (!dig_en_reg[gi] || blank_all) begin
                    seg_reg <= 8'hFF;
                end else begin
                    seg_reg <= {~dp_mask_reg[gi], seg7(value_reg[4*gi +: 4])};
                end
            end

            assign hex_bus[gi] = seg_reg;
        end
    endgenerate

    assign HEX0 = hex_bus[0];
    assign HEX1 = hex_bus[1];
    assign HEX2 = hex_bus[2];
    assign HEX3 = hex_bus[3];
    assign HEX4 = hex_bus[4];
    assign HEX5 = hex_bus[5];

endmodule

// File: tb/tb_hex_display_io.sv
// Self-checking bench for hex_display_io: directed cases plus randomized writes against a register model.
// Blink checks run only when HEX_DISPLAY_IO_BLINK_EN is defined.
module tb_hex_display_io;

    localparam int DIV = 4;
    localparam logic [7:0] SEG_TAB [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic        clk;
    logic        rst;
    logic        nce;
    logic        we;
    logic        re;
    logic [1:0]  addr;
    logic [31:0] d_in;
    logic [31:0] d_out;
    logic        d_oe;
    logic [7:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [7:0]  hex_obs [6];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference register model
    logic [23:0] m_value;
    logic [5:0]  m_dig;
    logic [5:0]  m_dp;
    logic        m_blink;

    hex_display_io #(.BLINK_DIV(DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .nce  (nce),
        .we   (we),
        .re   (re),
        .addr (addr),
        .d_in (d_in),
        .d_out(d_out),
        .d_oe (d_oe),
        .HEX0 (HEX0),
        .HEX1 (HEX1),
        .HEX2 (HEX2),
        .HEX3 (HEX3),
        .HEX4 (HEX4),
        .HEX5 (HEX5)
    );

    assign hex_obs[0] = HEX0;
    assign hex_obs[1] = HEX1;
    assign hex_obs[2] = HEX2;
    assign hex_obs[3] = HEX3;
    assign hex_obs[4] = HEX4;
    assign hex_obs[5] = HEX5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_value = '0;
        m_dig   = '0;
        m_dp    = '0;
        m_blink = 1'b0;
    endtask

    task automatic model_write(input logic [1:0] a, input logic [31:0] data);
        if (a == 2'd0) m_value = data[23:0];
        if (a == 2'd1) begin
            m_dig = data[5:0];
            m_dp  = data[11:6];
`ifdef HEX_DISPLAY_IO_BLINK_EN
            m_blink = data[12];
`else
            m_blink = 1'b0;
`endif
        end
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {8'd0, m_value};
            2'd1:    return {19'd0, m_blink, m_dp, m_dig};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [7:0] exp_hex(input int n, input logic blank);
        logic [7:0] t;
        logic [23:0] v;
        v = m_value >> (4 * n);
        if (!m_dig[n] || blank) return 8'hFF;
        t = SEG_TAB[v[3:0]];
        if (m_dp[n]) t[7] = 1'b0;
        return t;
    endfunction

    task automatic wr(input logic [1:0] a, input logic [31:0] data);
        nce = 1'b0; we = 1'b1; addr = a; d_in = data;
        tick();
        we = 1'b0; nce = 1'b1;
        model_write(a, data);
    endtask

    task automatic rd_check(input logic [1:0] a, input string tag);
        nce = 1'b0; re = 1'b1; addr = a;
        tick();
        check({tag, "_oe"}, {31'd0, d_oe}, 32'd1);
        check(tag, d_out, model_read(a));
        re = 1'b0; nce = 1'b1;
    endtask

    task automatic check_hex(input string tag, input logic blank);
        for (int n = 0; n < 6; n++) begin
            check($sformatf("%s_hex%0d", tag, n), {24'd0, hex_obs[n]}, {24'd0, exp_hex(n, blank)});
        end
    endtask

    initial begin
        logic [31:0] rv;
        logic [31:0] rc;
        logic [1:0]  ra;
        logic        ph;

        rst = 1'b1; nce = 1'b0; we = 1'b1; re = 1'b1; addr = 2'd0; d_in = 32'h00FFFFFF;
        model_reset();

        // Reset held for two cycles with a conflicting bus access
        tick();
        tick();
        rst = 1'b0; we = 1'b0; re = 1'b0; nce = 1'b1;
        check("rst_doe", {31'd0, d_oe}, 32'd0);
        check("rst_dout", d_out, 32'd0);
        check_hex("rst", 1'b0);
        for (int n = 0; n < 6; n++) check($sformatf("rst_blank%0d", n), {24'd0, hex_obs[n]}, 32'hFF);
        rd_check(2'd0, "rst_rd_value");
        rd_check(2'd1, "rst_rd_ctrl");
        tick();
        check("idle_doe", {31'd0, d_oe}, 32'd0);

        // All digits on, value written: HEX follows one cycle after the write edge
        wr(2'd1, 32'h0000003F);
        wr(2'd0, 32'h00012345);
        check("hex0_not_yet", {24'd0, HEX0}, 32'hC0);
        tick();
        check("d29_hex0", {24'd0, HEX0}, 32'h92);
        check("d29_hex1", {24'd0, HEX1}, 32'h99);
        check("d29_hex2", {24'd0, HEX2}, 32'hB0);
        check("d29_hex3", {24'd0, HEX3}, 32'hA4);
        check("d29_hex4", {24'd0, HEX4}, 32'hF9);
        check("d29_hex5", {24'd0, HEX5}, 32'hC0);

        // Upper CTRL bits masked to six digits, decimal points on digits 0 and 1
        wr(2'd1, 32'h000000C3);
        tick();
        check("d30_hex0", {24'd0, HEX0}, 32'h12);
        check("d30_hex1", {24'd0, HEX1}, 32'h19);
        check_hex("d30", 1'b0);

        // Simultaneous write and read returns the pre-write value
        wr(2'd1, 32'h0000003F);
        wr(2'd0, 32'h0000ABCD);
        nce = 1'b0; we = 1'b1; re = 1'b1; addr = 2'd0; d_in = 32'h00111111;
        tick();
        check("rw_dout", d_out, 32'h0000ABCD);
        check("rw_doe", {31'd0, d_oe}, 32'd1);
        we = 1'b0; re = 1'b0; nce = 1'b1;
        model_write(2'd0, 32'h00111111);
        rd_check(2'd0, "rw_after");
        check("rw_after_const", d_out, 32'h00111111);

        // Strobes ignored while deselected
        nce = 1'b1; we = 1'b1; re = 1'b1; addr = 2'd0; d_in = 32'h00FFFFFF;
        tick();
        check("nce_doe", {31'd0, d_oe}, 32'd0);
        tick();
        we = 1'b0; re = 1'b0;
        check_hex("nce", 1'b0);
        rd_check(2'd0, "nce_value");

`ifndef HEX_DISPLAY_IO_BLINK_EN
        // No blink feature: CTRL[12] is not stored and STATUS reads zero
        wr(2'd1, 32'h0000103F);
        rd_check(2'd1, "noblink_ctrl");
        check("noblink_ctrl_const", d_out, 32'h0000003F);
        rd_check(2'd2, "noblink_status");
`endif

        // Randomized register writes and readback
        for (int i = 0; i < 20; i++) begin
            rv = $urandom();
            rc = $urandom();
`ifdef HEX_DISPLAY_IO_BLINK_EN
            rc[12] = 1'b0;
`endif
            wr(2'd1, rc);
            wr(2'd0, rv);
            tick();
            check_hex($sformatf("rnd%0d", i), 1'b0);
            ra = 2'($urandom_range(0, 2));
            if (ra == 2'd2) ra = 2'd3;
            rd_check(ra, $sformatf("rnd%0d_rd%0d", i, ra));
            // Reserved write must not disturb anything
            wr(2'd3, $urandom());
            wr(2'd2, $urandom());
            rd_check(2'd0, $sformatf("rnd%0d_value", i));
        end

`ifdef HEX_DISPLAY_IO_BLINK_EN
        // Blink: phase holds for DIV cycles after a CTRL write, STATUS tracks it
        wr(2'd0, 32'h00012345);
        wr(2'd1, 32'h0000103F);
        nce = 1'b0; re = 1'b1; addr = 2'd2;
        for (int j = 1; j <= 4 * DIV; j++) begin
            tick();
            ph = (((j - 1) / DIV) % 2) == 1;
            check($sformatf("blink%0d_status", j), d_out, {31'd0, ph});
            check_hex($sformatf("blink%0d", j), ph);
        end
        re = 1'b0; nce = 1'b1;
        rd_check(2'd1, "blink_ctrl");
`endif

        // Reset during a read aborts it
        nce = 1'b0; re = 1'b1; addr = 2'd0;
        tick();
        check("rdrst_doe_before", {31'd0, d_oe}, 32'd1);
        rst = 1'b1;
        tick();
        check("rdrst_doe_after", {31'd0, d_oe}, 32'd0);
        check("rdrst_dout_after", d_out, 32'd0);
        rst = 1'b0; re = 1'b0; nce = 1'b1;
        model_reset();
        tick();
        check_hex("rdrst", 1'b0);
        rd_check(2'd0, "rdrst_value");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_display_io.md
HEX_DISPLAY_IO -- requirements
Module: hex_display_io

Interface
REQ-001 SHALL have parameter BLINK_DIV, default 25000000, meaning clock cycles per blink half-period (minimum 2).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port nce  input  1  active-low chip enable from the address decoder.
REQ-005 SHALL have port we  input  1  bus write strobe (MemWrite).
REQ-006 SHALL have port re  input  1  bus read strobe (MemRead).
REQ-007 SHALL have port addr  input  2  word select (bus addr[3:2]).
REQ-008 SHALL have port d_in  input  32  write data.
REQ-009 SHALL have port d_out  output  32  registered read data.
REQ-010 SHALL have port d_oe  output  1  high while d_out holds valid read data, for the top-level bus driver.
REQ-011 SHALL have ports HEX0..HEX5  output  8 each  active-low segments; bit7 = dp, bits6:0 = g..a.

Function
REQ-012 SHALL implement registers: addr 0 VALUE[23:0]; addr 1 CTRL = {blink_en[12], dp_mask[11:6], dig_en[5:0]}; addr 2 STATUS (read-only, bit0 = blink phase, bits 31:1 = 0); addr 3 reserved.
REQ-013 SHALL write a register on the clk edge where nce=0 and we=1; writes to addr 2 or 3 are ignored; unused upper bits are discarded.
REQ-014 SHALL, on an edge where nce=0 and re=1, load d_out with the selected register (zero-extended) and set d_oe=1 for exactly the next cycle; otherwise d_out=0 and d_oe=0.
REQ-015 SHALL, when we and re are both asserted, perform the write and return the pre-write register value.
REQ-016 SHALL have HEXn display nibble VALUE[4n+3:4n] using standard 0-F encoding (e.g. 0 -> 0xC0, 8 -> 0x80, F -> 0x8E with dp off).
REQ-017 SHALL drive HEXn bit7 low when dp_mask[n]=1.
REQ-018 SHALL drive HEXn = 0xFF (blank, dp included) when dig_en[n]=0.
REQ-019 SHALL register HEX outputs so a write is visible on HEX exactly one cycle after the register update edge.
REQ-020 SHALL run a blink counter 0..BLINK_DIV-1 that wraps to 0 and toggles blink phase on wrap.
REQ-021 SHALL blank all digits with dig_en=1 while blink_en=1 and phase=1.
REQ-022 SHALL, on any CTRL write, clear the blink counter and set phase=0 (visible) on the same edge.
REQ-023 SHALL ignore all bus strobes while nce=1.

Reset
REQ-024 SHALL, when rst=1 at a clk edge, clear VALUE, CTRL, blink counter, phase, d_out and d_oe to 0, and set HEX0..HEX5 to 0xFF, overriding any simultaneous bus access.
REQ-025 SHALL abort a read in progress on reset: d_oe=0 on the cycle after the reset edge.

Configuration
REQ-026 SHALL, with macro HEX_DISPLAY_IO_BLINK_EN defined, implement the blink counter, phase, and CTRL.blink_en as in REQ-020..022.
REQ-027 SHALL, without HEX_DISPLAY_IO_BLINK_EN, omit the counter, tie phase to 0, store no blink_en bit (reads return CTRL[12]=0), and keep STATUS=0.

Verification
REQ-028 SHALL cover: rst=1 for 2 cycles -> HEX0..HEX5=0xFF, d_oe=0, reads of addr 0/1 return 0.
REQ-029 SHALL cover: write CTRL=0x03F, then VALUE=0x012345 -> one cycle later HEX0=0x92, HEX1=0x99, HEX2=0xB0, HEX3=0xA4, HEX4=0xF9, HEX5=0xC0.
REQ-030 SHALL cover: CTRL=0x0C3 (dig 0,1,6,7 mask -> dig_en=0x03, dp_mask=0x03) -> HEX0/HEX1 bit7=0, HEX2..HEX5=0xFF.
REQ-031 SHALL cover: with BLINK_DIV=4 and HEX_DISPLAY_IO_BLINK_EN, CTRL=0x103F -> digits visible 4 cycles, blank 4 cycles, repeating; STATUS bit0 tracks phase.
REQ-032 SHALL cover: simultaneous we=1, re=1 to addr 0 with old VALUE=0x00ABCD, d_in=0x111111 -> d_out=0x0000ABCD, subsequent read returns 0x00111111.
REQ-033 SHALL cover: nce=1 with we=1 d_in=0xFFFFFF -> VALUE and HEX outputs unchanged; rst asserted during a read -> d_oe=0 next cycle.
